snc_ingress_arbiter: RTL and testbench
======================================

# snc_ingress_arbiter

Round-robin ingress arbiter and credit controller in front of the sequence-number checker (`seqNumCheck`). It shares the checker's single packet write port among `NUM_REQ` requesters. It also tracks how many packets are resident in each sequence-number bucket of the checker's reorder table, so that no bucket is written beyond its `NETWORK_SIZE` slots. Credits return when the checker hands a packet to the multiplier stage (`SNC_MUL_valid & !hlt`).

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters (≥2).
- `PACKET_SIZE`, 32 — packet width; must match the project header.
- `SEQ_WIDTH`, 2 — sequence-number width; there are 2**SEQ_WIDTH buckets.
- `SEQ_START`, 24 — bit offset of the sequence field in a packet.
- `NETWORK_SIZE`, 16 — slots per bucket, i.e. the credit limit per bucket.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  — system clock; all logic on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  — per-requester packet valid.
- `req_packet`  in  NUM_REQ*PACKET_SIZE  — packets; requester i occupies bits [i*PACKET_SIZE +: PACKET_SIZE].
- `req_ready`  out  NUM_REQ  — one-hot grant; the packet is accepted when `req_valid[i] & req_ready[i]`.
- `NI_SNC_valid`  out  1  — registered write strobe to the checker.
- `NI_SNC_packet`  out  PACKET_SIZE  — registered packet to the checker.
- `hlt`  in  1  — downstream halt; the same signal the checker sees.
- `SNC_MUL_valid`  in  1  — checker output valid.
- `SNC_MUL_seqNum`  in  SEQ_WIDTH  — sequence number of the packet being released.
- `credit_err`  out  1  — sticky error flag; see Configuration.

## Operation
- **Bucket selection.** The sequence field of requester i is `req_packet[i*PACKET_SIZE+SEQ_START +: SEQ_WIDTH]`.
- **Credit counters.**
  - One counter per bucket, `cnt[b]`, width $clog2(NETWORK_SIZE+1), range 0..NETWORK_SIZE.
  - Requester i is eligible when `req_valid[i]` is high and `cnt[its bucket] < NETWORK_SIZE`.
- **Arbitration.**
  - Round-robin pointer `rr`, width $clog2(NUM_REQ).
  - Search the eligible requesters starting at `rr` and increasing modulo NUM_REQ; the first one found is granted.
  - At most one grant per cycle. `req_ready` is combinational from the current state and inputs.
  - After a grant to requester g, `rr` becomes (g+1) mod NUM_REQ. With no grant, `rr` holds.
  - An ineligible (stalled) requester is skipped and does not block other buckets.
- **Issue.** On a grant:
  - `NI_SNC_packet` loads the granted packet.
  - `NI_SNC_valid` is 1 in the next cycle.
  - The granted bucket's `cnt` increments.
- **Release.** When `SNC_MUL_valid & !hlt`, `cnt[SNC_MUL_seqNum]` decrements.
- **Simultaneous events.**
  - Issue and release to the same bucket in one cycle: `cnt` is unchanged.
  - Issue and release to different buckets in one cycle: each updates independently.
  - A bucket at `NETWORK_SIZE` is not granted in the same cycle as its release; the freed credit is usable from the next cycle.
- **Underflow.** A release while `cnt == 0` leaves `cnt` at 0 (saturates). See Configuration for error reporting.
- **Idle output.** When there is no grant, `NI_SNC_valid` is 0 and `NI_SNC_packet` holds its last value.

## Timing
- Grant to checker write: 1 cycle. `NI_SNC_valid` and `NI_SNC_packet` are registered.
- Release to credit available: 1 cycle.
- Reset: on `rst`, in the same edge, all of the following clear:
  - `cnt[*]` = 0
  - `rr` = 0
  - `NI_SNC_valid` = 0
  - `NI_SNC_packet` = 0
  - `credit_err` = 0
- During the reset cycle `req_ready` is all zeros. Reset mid-stream drops any in-flight packet; the checker is reset alongside.
- Throughput: 1 packet/cycle when eligible requesters exist.

## Configuration
- Macro `SNC_ARB_CREDIT_ERR_EN`.
- **Defined:** `credit_err` sets, and stays set until `rst`, in either case:
  - a release arrives while `cnt[SNC_MUL_seqNum] == 0`;
  - an increment would exceed NETWORK_SIZE (defensive check).
- **Undefined:** the error logic is not compiled and `credit_err` is tied to 0. Counters still saturate.

## Test plan
- **Reset:** assert `rst` with all `req_valid`=1 → `req_ready`=0 and `NI_SNC_valid`=0 in the reset cycle. First grant after deassert goes to requester 0.
- **Fairness:** NUM_REQ=4, all requesters valid continuously, seq=0, no release → grants 0,1,2,3,0,… Each `NI_SNC_valid` pulse is one cycle after its grant, with the matching packet.
- **Credit full:** 16 packets issued to bucket 1, no release → `cnt[1]`=16. A requester for bucket 1 is stalled while a requester for bucket 2 keeps being granted.
- **Release with halt:** `SNC_MUL_valid`=1, `SNC_MUL_seqNum`=1, `hlt`=1 → no credit returned. Drop `hlt` → the bucket-1 requester is granted on the next cycle.
- **Simultaneous:** with `cnt[1]`=5, issue and release to bucket 1 in the same cycle → `cnt[1]` stays 5.
- **Underflow:** with `SNC_ARB_CREDIT_ERR_EN` defined, release to bucket 3 while `cnt[3]`=0 → `credit_err`=1 next cycle and stays set until `rst`; `cnt[3]` stays 0. With the macro undefined → `credit_err`=0.

Source files
------------

// File: rtl/snc_ingress_arbiter.sv
// rtl/snc_ingress_arbiter.sv - round-robin ingress arbiter and per-bucket credit controller for seqNumCheck
//
// Shares the checker's single packet write port among NUM_REQ requesters and
// keeps one credit counter per sequence-number bucket of the checker's reorder
// table. A bucket is never written beyond NETWORK_SIZE resident packets.
// Credits return when the checker releases a packet (SNC_MUL_valid & !hlt).
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   req_valid       per-requester packet valid
//   req_packet      packed requester packets, requester i at [i*PACKET_SIZE +: PACKET_SIZE]
//   req_ready       one-hot grant (combinational)
//   NI_SNC_valid    registered write strobe to the checker
//   NI_SNC_packet   registered packet to the checker
//   hlt             downstream halt shared with the checker
//   SNC_MUL_valid   checker output valid
//   SNC_MUL_seqNum  bucket of the packet being released
//   credit_err      sticky credit error flag
//
// Optional feature: define SNC_ARB_CREDIT_ERR_EN to compile the sticky
// credit_err detector; otherwise credit_err is tied to 0.

module snc_ingress_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PACKET_SIZE  = 32,
  parameter int SEQ_WIDTH    = 2,
  parameter int SEQ_START    = 24,
  parameter int NETWORK_SIZE = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PACKET_SIZE-1:0] req_packet,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           NI_SNC_valid,
  output logic [PACKET_SIZE-1:0]         NI_SNC_packet,
  input  logic                           hlt,
  input  logic                           SNC_MUL_valid,
  input  logic [SEQ_WIDTH-1:0]           SNC_MUL_seqNum,
  output logic                           credit_err
);

  localparam int NUM_BKT = 2**SEQ_WIDTH;
  localparam int CW      = $clog2(NETWORK_SIZE+1);
  localparam int RW      = $clog2(NUM_REQ);
  localparam logic [CW-1:0] CNT_MAX = CW'(NETWORK_SIZE);

  logic [CW-1:0]          cnt     [NUM_BKT];
  logic [CW-1:0]          cnt_nxt [NUM_BKT];
  logic [SEQ_WIDTH-1:0]   req_seq [NUM_REQ];
  logic [NUM_REQ-1:0]     elig;
  logic                   grant_vld;
  logic [RW-1:0]          grant_idx;
  logic [RW-1:0]          rr;
  logic [SEQ_WIDTH-1:0]   grant_seq;
  logic [PACKET_SIZE-1:0] grant_packet;
  logic                   rel;
  logic [NUM_BKT-1:0]     inc_hit;
  logic [NUM_BKT-1:0]     dec_hit;

  // Eligibility uses the current counter value only, so a full bucket being
  // released this cycle is not granted until the next cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_seq[i] = req_packet[i*PACKET_SIZE+SEQ_START +: SEQ_WIDTH];
      elig[i]    = req_valid[i] && (cnt[req_seq[i]] < CNT_MAX);
    end
  end

  // First eligible requester at or after rr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && elig[(int'(rr) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = RW'((int'(rr) + k) % NUM_REQ);
      end
    end
  end

  assign grant_seq    = req_seq[grant_idx];
  assign grant_packet = req_packet[int'(grant_idx)*PACKET_SIZE +: PACKET_SIZE];

  always_comb begin
    req_ready = '0;
    if (grant_vld && !rst) req_ready[grant_idx] = 1'b1;
  end

  assign rel = SNC_MUL_valid & ~hlt;

  // Issue and release to the same bucket cancel; each direction saturates.
  always_comb begin
    for (int b = 0; b < NUM_BKT; b++) begin
      inc_hit[b] = grant_vld && (grant_seq == SEQ_WIDTH'(b));
      dec_hit[b] = rel && (SNC_MUL_seqNum == SEQ_WIDTH'(b));
      cnt_nxt[b] = cnt[b];
      if (inc_hit[b] && !dec_hit[b] && (cnt[b] != CNT_MAX))
        cnt_nxt[b] = cnt[b] + 1'b1;
      else if (dec_hit[b] && !inc_hit[b] && (cnt[b] != '0))
        cnt_nxt[b] = cnt[b] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BKT; b++) cnt[b] <= '0;
      rr            <= '0;
      NI_SNC_valid  <= 1'b0;
      NI_SNC_packet <= '0;
    end else begin
      for (int b = 0; b < NUM_BKT; b++) cnt[b] <= cnt_nxt[b];
      NI_SNC_valid <= grant_vld;
      if (grant_vld) begin
        NI_SNC_packet <= grant_packet;
        rr            <= (grant_idx == RW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

`ifdef SNC_ARB_CREDIT_ERR_EN
  logic err_q;
  logic err_set;

  // Underflow: release into an empty bucket. Overflow: increment of a full
  // bucket, unreachable while eligibility gating is intact.
  always_comb begin
    err_set = 1'b0;
    for (int b = 0; b < NUM_BKT; b++) begin
      if (dec_hit[b] && (cnt[b] == '0)) err_set = 1'b1;
      if (inc_hit[b] && !dec_hit[b] && (cnt[b] == CNT_MAX)) err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign credit_err = err_q;
`else
  assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_snc_ingress_arbiter.sv
// tb/tb_snc_ingress_arbiter.sv - self-checking bench for snc_ingress_arbiter

module tb_snc_ingress_arbiter;

  localparam int N  = 4;
  localparam int PS = 32;
  localparam int SW = 2;
  localparam int SS = 24;
  localparam int NS = 16;
  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*PS-1:0] req_packet;
  logic [N-1:0]    req_ready;
  logic            NI_SNC_valid;
  logic [PS-1:0]   NI_SNC_packet;
  logic            hlt;
  logic            SNC_MUL_valid;
  logic [SW-1:0]   SNC_MUL_seqNum;
  logic            credit_err;

  snc_ingress_arbiter #(
    .NUM_REQ(N), .PACKET_SIZE(PS), .SEQ_WIDTH(SW), .SEQ_START(SS), .NETWORK_SIZE(NS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_packet(req_packet), .req_ready(req_ready),
    .NI_SNC_valid(NI_SNC_valid), .NI_SNC_packet(NI_SNC_packet),
    .hlt(hlt), .SNC_MUL_valid(SNC_MUL_valid), .SNC_MUL_seqNum(SNC_MUL_seqNum),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: resident packets per bucket, next-priority requester,
  // last issued packet, sticky error.
  int          m_cnt [NB];
  int          m_rr;
  bit          m_valid;
  logic [31:0] m_pkt;
  bit          m_err;
  logic [N-1:0] obs_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkpkt(input int s, input int pay);
    logic [31:0] p;
    p = 32'(pay);
    p[SS +: SW] = SW'(s);
    return p;
  endfunction

  function automatic int seq_of(input int i);
    return int'(req_packet[i*PS+SS +: SW]);
  endfunction

  task automatic set_req(input int i, input bit v, input logic [31:0] p);
    req_valid[i] = v;
    req_packet[i*PS +: PS] = p;
  endtask

  task automatic release_in(input bit v, input int s, input bit h);
    SNC_MUL_valid  = v;
    SNC_MUL_seqNum = SW'(s);
    hlt            = h;
  endtask

  // One clock cycle: predict the grant, check req_ready, clock, update the
  // model and check the registered outputs.
  task automatic cycle();
    int g, bestd, gs, s, n, dv;
    bit rel;
    logic [N-1:0] er;
    logic [31:0]  gp;
    g = -1;
    bestd = N;
    if (!rst)
      for (int i = 0; i < N; i++)
        if (req_valid[i] && m_cnt[seq_of(i)] < NS) begin
          dv = (i - m_rr + N) % N;
          if (dv < bestd) begin bestd = dv; g = i; end
        end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    gs  = (g >= 0) ? seq_of(g) : -1;
    gp  = (g >= 0) ? req_packet[g*PS +: PS] : 32'h0;
    rel = SNC_MUL_valid && !hlt;
    s   = int'(SNC_MUL_seqNum);
    #1;
    obs_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    #1;
    if (rst) begin
      for (int b = 0; b < NB; b++) m_cnt[b] = 0;
      m_rr = 0; m_valid = 0; m_pkt = 0; m_err = 0;
    end else begin
      m_valid = (g >= 0);
      if (g >= 0) begin m_pkt = gp; m_rr = (g + 1) % N; end
      for (int b = 0; b < NB; b++) begin
        if (rel && s == b && m_cnt[b] == 0) m_err = 1;
        n = m_cnt[b] + ((g >= 0 && gs == b) ? 1 : 0) - ((rel && s == b) ? 1 : 0);
        if (n < 0) n = 0;
        if (n > NS) n = NS;
        m_cnt[b] = n;
      end
    end
    chk("ni_valid", 32'(NI_SNC_valid), 32'(m_valid));
    chk("ni_packet", NI_SNC_packet, m_pkt);
`ifdef SNC_ARB_CREDIT_ERR_EN
    chk("credit_err", 32'(credit_err), 32'(m_err));
`else
    chk("credit_err", 32'(credit_err), 32'h0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int s;
    for (int b = 0; b < NB; b++) m_cnt[b] = 0;
    m_rr = 0; m_valid = 0; m_pkt = 0; m_err = 0;
    req_valid = '0;
    req_packet = '0;
    release_in(0, 0, 0);

    // Reset with every requester asserting valid.
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, mkpkt(0, 32'h100 + i));
    cycle();
    chk("rst_ready", 32'(obs_ready), 32'h0);
    chk("rst_ni_valid", 32'(NI_SNC_valid), 32'h0);
    cycle();
    rst = 1'b0;

    // Fairness: all valid on bucket 0.
    cycle();
    chk("first_grant", 32'(obs_ready), 32'h1);
    chk("first_packet", NI_SNC_packet, 32'h100);
    for (int c = 0; c < 7; c++) cycle();
    do_reset();

    // Credit full on bucket 1; bucket 2 keeps flowing.
    req_valid = '0;
    set_req(0, 1, mkpkt(1, 32'hA0));
    for (int c = 0; c < 16; c++) cycle();
    set_req(1, 1, mkpkt(2, 32'hB0));
    for (int c = 0; c < 3; c++) cycle();
    chk("stall_b1", 32'(obs_ready), 32'h2);

    // Release with halt returns nothing; dropping halt frees a credit.
    release_in(1, 1, 1);
    cycle();
    chk("halt_no_credit", 32'(obs_ready), 32'h2);
    release_in(1, 1, 0);
    cycle();
    chk("same_cycle_release", 32'(obs_ready), 32'h2);
    release_in(0, 0, 0);
    cycle();
    chk("b1_granted_after", 32'(obs_ready), 32'h1);
    do_reset();

    // Simultaneous issue and release to bucket 1 at count 5.
    req_valid = '0;
    set_req(0, 1, mkpkt(1, 32'hC0));
    for (int c = 0; c < 5; c++) cycle();
    release_in(1, 1, 0);
    cycle();
    release_in(0, 0, 0);
    for (int c = 0; c < 11; c++) cycle();
    cycle();
    chk("full_after_sim", 32'(obs_ready), 32'h0);
    do_reset();

    // Underflow on bucket 3.
    req_valid = '0;
    release_in(1, 3, 0);
    cycle();
    release_in(0, 0, 0);
    for (int c = 0; c < 3; c++) cycle();
`ifdef SNC_ARB_CREDIT_ERR_EN
    chk("underflow_sticky", 32'(credit_err), 32'h1);
`else
    chk("underflow_off", 32'(credit_err), 32'h0);
`endif
    set_req(0, 1, mkpkt(3, 32'hD0));
    cycle();
    cycle();
    chk("underflow_sat", 32'(NI_SNC_packet), 32'(mkpkt(3, 32'hD0)));
    do_reset();
    chk("err_cleared", 32'(credit_err), 32'h0);

    // Randomized traffic against the model; releases kept sparse so buckets fill.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 3) != 0), mkpkt(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535))));
      s = int'($urandom_range(0, 3));
      release_in(($urandom_range(0, 9) < 3) && (m_cnt[s] > 0), s, 1'($urandom_range(0, 3) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
